// File: rtl/dht_fnd_scanner.sv
// DHT sample -> checksum check -> shift-add-3 BCD conversion -> scanned FND glyph stream.
// One glyph code per scan position, with fixed/auto-rotating temperature and humidity pages.
module dht_fnd_scanner #(
  parameter int SCAN_DIV      = 100000,
  parameter int ROTATE_FRAMES = 250,
  parameter int DEC_DIGITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [7:0] temp_integral,
  input  logic [7:0] temp_decimal,
  input  logic [7:0] humi_integral,
  input  logic [7:0] humi_decimal,
  input  logic [7:0] parity,
  input  logic [1:0] i_mode,
  output logic [2:0] o_sel,
  output logic [4:0] o_code,
  output logic       o_page,
  output logic       o_err,
  output logic       o_busy,
  output logic       o_drop
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (ROTATE_FRAMES > 1) ? $clog2(ROTATE_FRAMES) : 1;

  localparam logic [4:0] G_DOT   = 5'h0a;
  localparam logic [4:0] G_BLANK = 5'h0f;
  localparam logic [4:0] G_T     = 5'h13;
  localparam logic [4:0] G_H     = 5'h16;
  localparam logic [4:0] G_E     = 5'h0e;
  localparam logic [4:0] G_R     = 5'h18;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD} state_t;

  // Sample handshake: i_valid is a single-cycle strobe with no ready. It is accepted
  // only while o_busy=0 (FSM in IDLE); any strobe seen while busy is discarded and
  // reported by a one-cycle o_drop pulse on the following cycle.
  state_t      state_q;
  logic [7:0]  shd_q [4];
  logic [11:0] res_q [4];
  logic [11:0] disp_q [4];
  logic [4:0]  cnt_q;
  logic [11:0] bcd_q;
  logic [7:0]  bin_q;
  logic        err_q;
  logic        busy_q;
  logic        drop_q;

  logic [7:0]  sum_w;
  logic        first_bit;
  logic [7:0]  cur_byte;
  logic [11:0] src_bcd;
  logic [7:0]  src_bin;
  logic [19:0] shift_w;
  logic [11:0] bcd_d;
  logic [7:0]  bin_d;

  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int n = 0; n < 3; n++) begin
      if (r[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign sum_w = temp_integral + temp_decimal + humi_integral + humi_decimal;

  // Bit 0 of each byte starts from a cleared BCD accumulator and the next shadow byte.
  always_comb begin
    first_bit = (cnt_q[2:0] == 3'd0);
    cur_byte  = shd_q[cnt_q[4:3]];
    src_bcd   = first_bit ? 12'd0 : bcd_q;
    src_bin   = first_bit ? cur_byte : bin_q;
    shift_w   = {add3(src_bcd), src_bin} << 1;
    bcd_d     = shift_w[19:8];
    bin_d     = shift_w[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < 4; i++) begin
        shd_q[i]  <= '0;
        res_q[i]  <= '0;
        disp_q[i] <= '0;
      end
      cnt_q  <= '0;
      bcd_q  <= '0;
      bin_q  <= '0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= i_valid && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            if (sum_w != parity) begin
              err_q <= 1'b1;
            end else begin
              shd_q[0] <= temp_integral;
              shd_q[1] <= temp_decimal;
              shd_q[2] <= humi_integral;
              shd_q[3] <= humi_decimal;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= S_CONV;
            end
          end
        end
        S_CONV: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          if (cnt_q[2:0] == 3'd7) res_q[cnt_q[4:3]] <= bcd_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= S_LOAD;
        end
        S_LOAD: begin
          for (int i = 0; i < 4; i++) disp_q[i] <= res_q[i];
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Scan side: prescaler, position, page/frame bookkeeping and registered glyph.
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    sel_q, sel_d;
  logic          page_q, page_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          in_auto_q, in_auto_d;
  logic [4:0]    code_q, code_d;
  logic          tc;
  logic          boundary;
  logic [11:0]   ib_w;
  logic [7:0]    db_w;

  function automatic logic [4:0] glyph(input logic [2:0] pos, input logic pg,
                                       input logic err, input logic [11:0] ib,
                                       input logic [7:0] db);
    logic [4:0] g;
    g = G_BLANK;
    if (err) begin
      case (pos)
        3'd3:       g = G_E;
        3'd2, 3'd1: g = G_R;
        default:    g = G_BLANK;
      endcase
    end else begin
      case (pos)
        3'd0: g = (DEC_DIGITS == 2) ? {1'b0, db[7:4]} : {1'b0, db[3:0]};
        3'd1: g = {1'b0, ib[3:0]};
        3'd2: g = (ib[11:4] == 8'd0) ? G_BLANK : {1'b0, ib[7:4]};
        3'd3: g = pg ? G_H : G_T;
        3'd4: g = (ib[11:8] == 4'd0) ? G_BLANK : {1'b0, ib[11:8]};
        3'd5: g = G_DOT;
        3'd7: g = (DEC_DIGITS == 2) ? {1'b0, db[3:0]} : G_BLANK;
        default: g = G_BLANK;
      endcase
    end
    return g;
  endfunction

  always_comb begin
    tc        = (presc_q == PW'(SCAN_DIV - 1));
    boundary  = tc && (sel_q == 3'd7);
    presc_d   = tc ? '0 : presc_q + PW'(1);
    sel_d     = tc ? sel_q + 3'd1 : sel_q;
    page_d    = page_q;
    frame_d   = frame_q;
    in_auto_d = in_auto_q;
    // Page decisions are only taken at the 7->0 wrap so a frame never splits pages.
    if (boundary) begin
      if (!i_mode[1]) begin
        page_d    = i_mode[0];
        frame_d   = '0;
        in_auto_d = 1'b0;
      end else begin
        in_auto_d = 1'b1;
        if (!in_auto_q) begin
          frame_d = '0;
        end else if (frame_q == FW'(ROTATE_FRAMES - 1)) begin
          page_d  = ~page_q;
          frame_d = '0;
        end else begin
          frame_d = frame_q + FW'(1);
        end
      end
    end
    ib_w   = page_d ? disp_q[2] : disp_q[0];
    db_w   = page_d ? disp_q[3][7:0] : disp_q[1][7:0];
    code_d = glyph(sel_d, page_d, err_q, ib_w, db_w);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      sel_q     <= '0;
      page_q    <= 1'b0;
      frame_q   <= '0;
      in_auto_q <= 1'b0;
      code_q    <= G_BLANK;
    end else begin
      presc_q   <= presc_d;
      sel_q     <= sel_d;
      page_q    <= page_d;
      frame_q   <= frame_d;
      in_auto_q <= in_auto_d;
      code_q    <= code_d;
    end
  end

  assign o_sel  = sel_q;
  assign o_code = code_q;
  assign o_page = page_q;
  assign o_err  = err_q;
  assign o_busy = busy_q;
  assign o_drop = drop_q;

endmodule
